// File: rtl/nvram_uploader.sv
// Serves the 1024x4 CMOS RAM to the HPS over the ioctl upload path and requests a save after write activity settles.
// Optional NVRAM_SUM_EN: bytes 0x400/0x401 return an 8-bit checksum of 0x000..0x3FF and its complement.
module nvram_uploader #(
  parameter logic [7:0] INDEX        = 8'd4,
  parameter int         QUIET_FRAMES = 60,
  parameter int         RD_LAT       = 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cpu_cmos_we,
  input  logic        frame_tick,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [16:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        ioctl_upload_req,
  output logic [9:0]  cmos_addr,
  output logic        cmos_rd,
  input  logic [3:0]  cmos_q,
  output logic        nvram_dirty
);

  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  state_t      state, state_nxt;
  logic        active, accept, addr_lo, addr_q_lo;
  logic [16:0] addr_q;
  logic [1:0]  lat_cnt;
  logic [7:0]  quiet_cnt;
  logic        dirty;
  logic [7:0]  rd_byte;

  assign active    = ioctl_upload && (ioctl_index == INDEX);
  // reset_n is folded in so the combinational outputs read 0 while reset is held
  assign accept    = reset_n && (state == IDLE) && ioctl_rd && active;
  assign addr_lo   = (ioctl_addr[16:10] == 7'd0);
  assign addr_q_lo = (addr_q[16:10] == 7'd0);

  assign cmos_rd     = accept && addr_lo;
  assign cmos_addr   = accept ? ioctl_addr[9:0] : addr_q[9:0];
  assign ioctl_wait  = accept || (state != IDLE);
  assign nvram_dirty = dirty;

`ifdef NVRAM_SUM_EN
  logic [7:0] sum;
  always_comb begin
    rd_byte = 8'hFF;
    if (addr_q_lo)                rd_byte = {4'hF, cmos_q};
    else if (addr_q == 17'h00400) rd_byte = sum;
    else if (addr_q == 17'h00401) rd_byte = ~sum;
  end
`else
  assign rd_byte = addr_q_lo ? {4'hF, cmos_q} : 8'hFF;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (!active) state_nxt = IDLE;
               else if (lat_cnt <= 2'd1) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      addr_q    <= '0;
      lat_cnt   <= '0;
      ioctl_din <= 8'h00;
`ifdef NVRAM_SUM_EN
      sum       <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q  <= ioctl_addr;
          lat_cnt <= 2'(RD_LAT);
`ifdef NVRAM_SUM_EN
          if (ioctl_addr == 17'h0) sum <= 8'h00;
`endif
        end
        WAIT: if (active) lat_cnt <= lat_cnt - 2'd1;
        OUT: if (active) begin
          ioctl_din <= rd_byte;
`ifdef NVRAM_SUM_EN
          if (addr_q_lo) sum <= sum + rd_byte;
`endif
        end
        default: ;
      endcase
    end
  end

  // A CPU write always beats a coincident frame tick; the count is frozen during an upload
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      quiet_cnt        <= 8'd0;
      dirty            <= 1'b0;
      ioctl_upload_req <= 1'b0;
    end else begin
      ioctl_upload_req <= 1'b0;
      if (cpu_cmos_we) begin
        dirty     <= 1'b1;
        quiet_cnt <= 8'd0;
      end else if (frame_tick && dirty && !ioctl_upload) begin
        if (quiet_cnt == 8'(QUIET_FRAMES - 1)) begin
          ioctl_upload_req <= 1'b1;
          dirty            <= 1'b0;
          quiet_cnt        <= 8'd0;
        end else begin
          quiet_cnt <= quiet_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nvram_uploader.sv
// Scoreboard bench for nvram_uploader: reset, quiet-frame request timing, read latency, abort and trailer bytes.
module tb_nvram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset_n, cpu_cmos_we, frame_tick, ioctl_upload, ioctl_rd, cmos_rd;
  logic        ioctl_wait, ioctl_upload_req, nvram_dirty;
  logic [7:0]  ioctl_index, ioctl_din;
  logic [16:0] ioctl_addr;
  logic [9:0]  cmos_addr;
  logic [3:0]  cmos_q;

  always #5 clk_sys = ~clk_sys;

  nvram_uploader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .cpu_cmos_we(cpu_cmos_we), .frame_tick(frame_tick),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .cmos_addr(cmos_addr), .cmos_rd(cmos_rd),
    .cmos_q(cmos_q), .nvram_dirty(nvram_dirty)
  );

  // CMOS RAM model, one cycle read latency, output held between reads
  logic [3:0] mem [1024];
  always @(posedge clk_sys) if (cmos_rd) cmos_q <= mem[cmos_addr];

  int total = 0, bad = 0, req_hi = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_din, msum;

  always @(negedge clk_sys) if (reset_n && ioctl_upload_req) req_hi++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [16:0] a);
    if (a < 17'h400) return {4'hF, mem[a[9:0]]};
`ifdef NVRAM_SUM_EN
    if (a == 17'h400) return msum;
    if (a == 17'h401) return ~msum;
`endif
    return 8'hFF;
  endfunction

  task automatic do_read(input logic [16:0] a, input string tag);
    logic [7:0] e;
    int n;
    bit ok;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b1; ioctl_addr = a;
    e = model_byte(a);
    if (a == 17'h0) msum = 8'h00;
    if (a < 17'h400) msum = msum + e;
    exp_q.push_back(e);
    @(negedge clk_sys);
    chk({tag, "_rd0"}, {31'd0, cmos_rd}, {31'd0, (a < 17'h400)});
    chk({tag, "_wait0"}, {31'd0, ioctl_wait}, 32'd1);
    if (a < 17'h400) chk({tag, "_caddr"}, {22'd0, cmos_addr}, {22'd0, a[9:0]});
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    n = 0; ok = 1'b0;
    repeat (10) begin
      @(negedge clk_sys);
      n++;
      if (!ioctl_wait) begin ok = 1'b1; break; end
    end
    chk({tag, "_lat"}, n, 3);
    e = exp_q.pop_front();
    if (ok) begin
      chk({tag, "_din"}, {24'd0, ioctl_din}, {24'd0, e});
      last_din = e;
    end
  endtask

  task automatic tick(input bit we, output bit pulse);
    @(posedge clk_sys); #1;
    frame_tick = 1'b1; cpu_cmos_we = we;
    @(posedge clk_sys); #1;
    frame_tick = 1'b0; cpu_cmos_we = 1'b0;
    @(negedge clk_sys);
    pulse = ioctl_upload_req;
  endtask

  initial begin
    bit p;
    int pulses, base;
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
    mem[5] = 4'h3; mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h3; mem[10'h3FF] = 4'hA;
    msum = 8'h00; last_din = 8'h00;
    reset_n = 1'b0; cpu_cmos_we = 1'b0; frame_tick = 1'b0; ioctl_upload = 1'b0;
    ioctl_index = 8'd0; ioctl_rd = 1'b0; ioctl_addr = '0;

    // reset with random inputs
    repeat (3) begin
      @(posedge clk_sys); #1;
      cpu_cmos_we = 1'($urandom); frame_tick = 1'($urandom); ioctl_upload = 1'($urandom);
      ioctl_index = ($urandom_range(0, 1) == 1) ? 8'd4 : 8'($urandom);
      ioctl_rd = 1'($urandom); ioctl_addr = 17'($urandom);
      @(negedge clk_sys);
      chk("rst_out", {10'd0, ioctl_din, ioctl_wait, ioctl_upload_req, cmos_addr, cmos_rd, nvram_dirty}, 32'd0);
    end
    @(posedge clk_sys); #1;
    cpu_cmos_we = 1'b0; frame_tick = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0;
    ioctl_index = 8'd4; ioctl_addr = '0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;

    // one write then 60 quiet frames
    base = req_hi;
    @(posedge clk_sys); #1; cpu_cmos_we = 1'b1;
    @(posedge clk_sys); #1; cpu_cmos_we = 1'b0;
    @(negedge clk_sys);
    chk("dirty_set", {31'd0, nvram_dirty}, 32'd1);
    pulses = 0;
    for (int i = 1; i < 60; i++) begin tick(1'b0, p); pulses += int'(p); end
    chk("no_early_req", pulses, 0);
    chk("dirty_held", {31'd0, nvram_dirty}, 32'd1);
    tick(1'b0, p);
    chk("req_tick60", {31'd0, p}, 32'd1);
    chk("dirty_clr", {31'd0, nvram_dirty}, 32'd0);
    repeat (3) @(negedge clk_sys);
    chk("req_one_cycle", req_hi - base, 1);

    // write coincident with tick 31 restarts the count
    base = req_hi;
    @(posedge clk_sys); #1; cpu_cmos_we = 1'b1;
    @(posedge clk_sys); #1; cpu_cmos_we = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin tick(1'b0, p); pulses += int'(p); end
    tick(1'b1, p); pulses += int'(p);
    for (int i = 1; i < 60; i++) begin tick(1'b0, p); pulses += int'(p); end
    chk("coinc_no_req", pulses, 0);
    chk("coinc_dirty", {31'd0, nvram_dirty}, 32'd1);
    tick(1'b0, p);
    chk("coinc_req60", {31'd0, p}, 32'd1);
    repeat (2) @(negedge clk_sys);
    chk("coinc_one_req", req_hi - base, 1);

    // basic reads and the 0x400 boundary
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    do_read(17'h00005, "rd005");
    do_read(17'h003FF, "rd3ff");
    do_read(17'h00402, "rd402");
    do_read(17'h1FFFF, "rdtop");

    // wrong index: ignored
    ioctl_index = 8'd0;
    @(posedge clk_sys); #1; ioctl_rd = 1'b1; ioctl_addr = 17'h5;
    @(negedge clk_sys);
    chk("inact_rd", {31'd0, cmos_rd}, 32'd0);
    chk("inact_wait0", {31'd0, ioctl_wait}, 32'd0);
    @(posedge clk_sys); #1; ioctl_rd = 1'b0;
    pulses = 0;
    repeat (4) begin @(negedge clk_sys); pulses += int'(ioctl_wait); end
    chk("inact_wait", pulses, 0);
    chk("inact_din", {24'd0, ioctl_din}, {24'd0, last_din});

    // drop upload while in WAIT
    ioctl_index = 8'd4;
    @(posedge clk_sys); #1; ioctl_rd = 1'b1; ioctl_addr = 17'h7;
    @(posedge clk_sys); #1; ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("abort_wait", {31'd0, ioctl_wait}, 32'd0);
    repeat (3) @(negedge clk_sys);
    chk("abort_din", {24'd0, ioctl_din}, {24'd0, last_din});
    ioctl_upload = 1'b1;

    // checksum trailer
    do_read(17'h00000, "sum0");
    do_read(17'h00001, "sum1");
    do_read(17'h00002, "sum2");
    do_read(17'h00400, "sum400");
    do_read(17'h00401, "sum401");
    do_read(17'h00400, "sum400b");
`ifdef NVRAM_SUM_EN
    chk("sum_const", {24'd0, msum}, 32'hD6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nvram_uploader.md
Name: nvram_uploader

Overview:
- Serves the Williams CMOS high-score/settings RAM (1024 x 4 bit) to the HPS over the ioctl upload path, so NVRAM can be saved to SD.
- Requests uploads itself: raises ioctl_upload_req once CPU writes to CMOS have been quiet for a set number of frames.
- Sits beside the williams2 core in emu. It owns a read-only second port on the CMOS RAM and is the return path complementing the ROM/NVRAM download path.

Parameters:
- INDEX, 8'd4: ioctl_index value that selects NVRAM upload.
- QUIET_FRAMES, 60: frame_tick count with no CMOS write before a request is raised (1..255).
- RD_LAT, 1: cycles from cmos_rd to valid cmos_q (1..3).

Ports:
- clk_sys  in  1  system clock (12 MHz)
- reset_n  in  1  synchronous, active-low reset
- cpu_cmos_we  in  1  one-cycle strobe for each CPU write to CMOS
- frame_tick  in  1  one-cycle pulse at vblank start
- ioctl_upload  in  1  HPS upload in progress
- ioctl_index  in  8  upload target index
- ioctl_rd  in  1  HPS read strobe, one cycle
- ioctl_addr  in  17  byte address of the read
- ioctl_din  out  8  read data to HPS
- ioctl_wait  out  1  HPS must hold off further reads
- ioctl_upload_req  out  1  one-cycle upload request pulse
- cmos_addr  out  10  CMOS read address
- cmos_rd  out  1  CMOS read strobe
- cmos_q  in  4  CMOS read data
- nvram_dirty  out  1  unsaved CMOS writes are pending

Behaviour:
- Reset (reset_n=0 at a clk_sys edge): all outputs 0, ioctl_din=8'h00, FSM=IDLE, quiet counter=0, dirty=0.
- active = ioctl_upload && (ioctl_index == INDEX).

Request generator:
- cpu_cmos_we sets dirty and clears the quiet counter. This holds in every state, including during an upload.
- On frame_tick with dirty=1 and ioctl_upload=0, the counter increments.
- When the increment reaches QUIET_FRAMES:
  - ioctl_upload_req pulses high for exactly 1 cycle;
  - dirty clears;
  - the counter returns to 0.
- If cpu_cmos_we and frame_tick coincide, the write wins: the counter goes to 0 and no request is raised.
- The counter is frozen while ioctl_upload=1.
- nvram_dirty = dirty.

Upload FSM (states IDLE, WAIT, OUT):
- IDLE:
  - On ioctl_rd && active, latch ioctl_addr.
  - If addr < 0x400: drive cmos_addr = addr[9:0] and cmos_rd = 1 for 1 cycle.
  - Go to WAIT with lat_cnt = RD_LAT.
  - ioctl_rd while inactive is ignored.
- WAIT: decrement lat_cnt each cycle; at 0, go to OUT.
- OUT, for addr < 0x400: ioctl_din <= {4'hF, cmos_q}. The upper nibble reads as 1s, as on the original board.
- OUT, for addr >= 0x400: ioctl_din <= 8'hFF and no cmos_rd is issued, at the same latency. The exception is the trailer bytes when the optional feature is enabled.
- OUT then returns to IDLE.

Handshake and timing:
- ioctl_wait = (ioctl_rd && active) | (state != IDLE). It is high combinationally in the ioctl_rd cycle and stays high through OUT.
- ioctl_din is valid and ioctl_wait is low from RD_LAT+2 cycles after ioctl_rd (cycle 0 = rd).
- ioctl_din holds its value until the next completed read.
- ioctl_rd while state != IDLE is ignored.

Abort and reset mid-operation:
- If active drops while in WAIT or OUT: FSM returns to IDLE on the next cycle, ioctl_wait goes low, cmos_rd=0, ioctl_din is unchanged.
- Reset mid-operation behaves as reset.

Optional Feature:
- Macro: NVRAM_SUM_EN.
- Defined:
  - An 8-bit accumulator clears when a read of addr 0x000 is accepted.
  - It adds each byte returned for addr 0x000..0x3FF, modulo 256.
  - A read of 0x400 returns the sum; a read of 0x401 returns ~sum. Reads of either do not modify the sum.
  - Addresses >= 0x402 return 8'hFF.
- Undefined: no accumulator; every addr >= 0x400 returns 8'hFF.

Test Plan:
- Hold reset_n=0 for 3 cycles with random inputs -> every output 0, ioctl_din=8'h00.
- One cpu_cmos_we, then 60 frame_ticks (QUIET_FRAMES=60) -> no ioctl_upload_req on ticks 1..59, exactly one 1-cycle pulse on tick 60, nvram_dirty falls with it.
- Write, 30 ticks, write again coincident with tick 31 -> counter 0, no pulse; the pulse arrives 60 ticks after the second write.
- active, RD_LAT=1, ioctl_rd at addr 0x005, cmos_q=4'h3:
  - cycle 0: cmos_addr=0x005, cmos_rd=1, ioctl_wait=1;
  - cycle 3: ioctl_din=8'hF3, ioctl_wait=0.
- ioctl_index=8'd0 (not INDEX) with ioctl_rd -> no cmos_rd, ioctl_wait stays 0, ioctl_din unchanged. Separately, drop ioctl_upload in WAIT -> IDLE next cycle, ioctl_wait=0.
- NVRAM_SUM_EN defined, read 0x000..0x002 with cmos_q=1,2,3, then 0x400 and 0x401 -> 8'hD6 and 8'h29. Undefined, the same reads -> 8'hFF and 8'hFF.
